// File: rtl/booth_r4_mul.sv
// booth_r4_mul: sequential radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU, one digit per clock.
module booth_r4_mul #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          kill,
  input  logic [1:0]    op,
  input  logic [DW-1:0] multiplicand,
  input  logic [DW-1:0] multiplier,
  output logic [DW-1:0] result,
  output logic          busy,
  output logic          done
);
  localparam int AW = 2*DW + 4;
  localparam int BW = DW + 3;
  localparam int CW = $clog2(DW/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(DW/2);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [AW-1:0] acc, a_sh, pp, acc_nx, a_init;
  logic [BW-1:0] b_sh, b_init;
  logic [2:0]    dig;
  logic          s_a, s_b, accept;
  assign s_a    = (op != 2'b11) & multiplicand[DW-1];
  assign s_b    = ~op[1] & multiplier[DW-1];
  assign a_init = {{(AW-DW){s_a}}, multiplicand};
  // low bit is the implicit B[-1] = 0 of the first Booth triplet
  assign b_init = {{2{s_b}}, multiplier, 1'b0};
  assign accept = start & ~kill & ((state == IDLE) | (state == DONE));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);
  // a_sh already carries the 4^i weight, b_sh presents the current triplet in its low bits
  always_comb begin
    dig    = b_sh[2:0];
    pp     = (dig == 3'b011) ? (a_sh << 1) :
             (dig == 3'b100) ? -(a_sh << 1) :
             (dig == 3'b001 || dig == 3'b010) ? a_sh :
             (dig == 3'b101 || dig == 3'b110) ? -a_sh : '0;
    acc_nx = acc + pp;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= '0;
      result <= '0;
    end else if (accept) begin
      state <= CALC;
      cnt   <= '0;
      acc   <= '0;
      a_sh  <= a_init;
      b_sh  <= b_init;
      op_q  <= op;
    end else if (state == CALC) begin
      if (kill) begin
        state <= IDLE;
      end else begin
        acc  <= acc_nx;
        a_sh <= a_sh << 2;
        b_sh <= BW'($signed(b_sh) >>> 2);
        cnt  <= cnt + 1'b1;
        if (cnt == LAST) begin
          result <= (op_q == 2'b00) ? acc_nx[DW-1:0] : acc_nx[2*DW-1:DW];
          state  <= DONE;
        end
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: randomized and directed checks of booth_r4_mul against a 64-bit arithmetic reference.
module tb_booth_r4_mul;
  logic        clk, rst_n, start, kill;
  logic [1:0]  op;
  logic [31:0] multiplicand, multiplier, result;
  logic        busy, done;
  int n_cmp = 0;
  int n_err = 0;

  booth_r4_mul #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .result(result), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = (o != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
    bx = (o[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ax * bx;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // launches one op and waits (bounded) for done; reports latency, busy cycles and busy/done overlap
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output int bcyc, output bit ovl);
    @(negedge clk);
    op = o; multiplicand = a; multiplier = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; bcyc = 0; ovl = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) ovl = 1'b1;
    r = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({result, busy, done} !== 34'h0) begin
      n_err++; $display("FAIL reset: result=%h busy=%b done=%b required 0/0/0", result, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  vo [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] va [7] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2};
    logic [31:0] vb [7] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ve [7] = '{32'hFFFFFFEB, 32'h40000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1};
    logic [31:0] r;
    int lat, bcyc;
    bit ovl;
    for (int i = 0; i < 7; i++) begin
      do_op(vo[i], va[i], vb[i], r, lat, bcyc, ovl);
      n_cmp++;
      if (r !== ve[i]) begin
        n_err++; $display("FAIL directed[%0d] result: got %h required %h", i, r, ve[i]);
      end
      n_cmp++;
      if (lat !== 17 || bcyc !== 17) begin
        n_err++; $display("FAIL directed[%0d] timing: latency %0d busy %0d required 17/17", i, lat, bcyc);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b one cycle after DONE, required 0", done);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, exp;
    logic [1:0]  o;
    logic [31:0] corner [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
    int lat, bcyc;
    bit ovl;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      exp = ref_mul(o, a, b);
      do_op(o, a, b, r, lat, bcyc, ovl);
      n_cmp++;
      if (r !== exp) begin
        n_err++; $display("FAIL random op=%0d a=%h b=%h: got %h required %h", o, a, b, r, exp);
      end
      n_cmp++;
      if (lat !== 17 || ovl) begin
        n_err++; $display("FAIL random timing op=%0d a=%h b=%h: latency %0d overlap %b required 17/0", o, a, b, lat, ovl);
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat, bcyc, dcnt;
    bit ovl;
    do_op(2'b00, 32'h1234, 32'h1, r, lat, bcyc, ovl);
    n_cmp++;
    if (r !== 32'h1234) begin
      n_err++; $display("FAIL kill_setup: got %h required 00001234", r);
    end
    @(negedge clk);
    op = 2'b00; multiplicand = 32'd100; multiplier = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b00 || result !== 32'h1234) begin
      n_err++; $display("FAIL kill: busy=%b done=%b result=%h required 0/0/00001234", busy, done, result);
    end
    dcnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0) begin
      n_err++; $display("FAIL kill_quiet: %0d active cycles after kill, required 0", dcnt);
    end
    @(negedge clk); kill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL kill_over_start: busy=%b required 0", busy);
    end
    do_op(2'b00, 32'd100, 32'd100, r, lat, bcyc, ovl);
    n_cmp++;
    if (r !== 32'h2710 || lat !== 17) begin
      n_err++; $display("FAIL kill_recover: got %h latency %0d required 00002710/17", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [31:0] r1;
    @(negedge clk);
    op = 2'b00; multiplicand = 32'd6; multiplier = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    op = 2'b11; multiplicand = 32'h10000; multiplier = 32'h10000;
    n1 = 0;
    while (!done && n1 < 40) begin @(posedge clk); #1; n1++; end
    r1 = result;
    n2 = 0;
    do begin @(posedge clk); #1; n2++; end while (!done && n2 < 40);
    start = 1'b0;
    n_cmp++;
    if (r1 !== 32'h2A || n1 !== 17) begin
      n_err++; $display("FAIL b2b_first: got %h after %0d edges required 0000002a/17", r1, n1);
    end
    n_cmp++;
    if (result !== 32'h1 || n2 !== 18) begin
      n_err++; $display("FAIL b2b_second: got %h after %0d edges required 00000001/18", result, n2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int act;
    @(negedge clk);
    op = 2'b01; multiplicand = 32'hFFFFFFFF; multiplier = 32'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({result, busy, done} !== 34'h0) begin
      n_err++; $display("FAIL async_reset: result=%h busy=%b done=%b required 0/0/0", result, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    act = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_err++; $display("FAIL async_reset_idle: %0d active cycles after release, required 0", act);
    end
    @(negedge clk); rst_n = 1'b0; start = 1'b1; op = 2'b00; multiplicand = 32'd3; multiplier = 32'd5;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL reset_pending_start: busy=%b required 1", busy);
    end
    act = 0;
    while (!done && act < 40) begin @(posedge clk); #1; act++; end
    n_cmp++;
    if (result !== 32'd15 || act !== 17) begin
      n_err++; $display("FAIL reset_pending_result: got %h latency %0d required 0000000f/17", result, act);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/booth_r4_mul.md
# booth_r4_mul

Sequential radix-4 Booth multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU), the multiply counterpart of the pipeline's iterative divider in the execute stage. It accepts one operation per start pulse, retires one Booth digit per clock over a fixed 17-cycle iteration, and returns the selected 32-bit half of the 64-bit product with a one-cycle done pulse. A kill input lets the pipeline abort an in-flight multiply on flush.

## Interface
- DW, 32: operand/result width. Only 32 is verified.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled in IDLE or DONE only.
- kill  input  1  abort in-flight operation; priority over start.
- op  input  2  00 MUL (low word, signed×signed), 01 MULH (high, signed×signed), 10 MULHSU (high, signed multiplicand × unsigned multiplier), 11 MULHU (high, unsigned×unsigned).
- multiplicand  input  DW  rs1 operand; captured on the accepting edge.
- multiplier  input  DW  rs2 operand; captured on the accepting edge.
- result  output  DW  selected product half; registered.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid in that cycle.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; result = 0, busy = 0, done = 0, counter = 0, accumulator = 0.
- IDLE: start=1 and kill=0 → capture operands and op, clear accumulator, counter = 0, go to CALC. Otherwise stay.
- CALC: each edge consumes one Booth digit i (0..16) from triplet {B[2i+1], B[2i], B[2i-1]}, B[-1] = 0; partial product ∈ {0, ±A, ±2A}, added at weight 4^i. When counter = 16, the final digit is added, result is loaded, and the FSM goes to DONE. start is ignored. kill=1 → IDLE on the next edge; result unchanged; done never pulses for the killed operation.
- DONE: done = 1 for exactly this cycle. Next edge: start=1 and kill=0 → accept a new operation (as from IDLE), otherwise → IDLE.
- Operand extension to 34 bits: A is sign-extended for op 00/01/10 and zero-extended for op 11. B is sign-extended for op 00/01 and zero-extended for op 10/11.
- Accumulator is at least 68 bits, two's complement. The product is the low 64 bits. result = product[31:0] for op 00 and product[63:32] otherwise.
- Latency is fixed with no zero-operand early exit. Operand values of 0, 1 and −1 take the same 17 cycles.
- result holds its last value through IDLE, CALC and kill. It changes only on the CALC→DONE edge.
- busy = (state == CALC). done = (state == DONE). busy and done are never high together.

## Timing
- start accepted at edge E0 → busy high after E0 → busy low and done high after E17 → done low after E18.
- Back-to-back: start accepted at the E17+1 edge (DONE cycle) → next done after E35. Throughput is one operation per 18 cycles.
- kill sampled at any CALC edge → state IDLE and busy low after that edge.
- kill and start both high in IDLE/DONE → kill wins, state IDLE.
- rst_n low at any time → all outputs 0 immediately (asynchronous). After release, the FSM is in IDLE and a pending start is accepted at the first edge with rst_n high.
- Inputs are required stable only around the accepting edge. Changes during CALC have no effect.

## Test plan
- MUL: 7 × −3 (0xFFFFFFFD) → result 0xFFFFFFEB. done exactly 17 edges after the accepting edge, busy high for 17 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MUL on the same operands → 0x00000000. MULH 0xFFFFFFFF × 0x00000001 → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHSU 0x00000002 × 0x80000000 → 0x00000001.
- kill on the 5th CALC cycle of 100×100 (previous result 0x1234) → no done pulse, busy low next cycle, result stays 0x1234. A following MUL 100×100 → 0x00002710 after 17 cycles.
- start held high continuously with alternating operands (6×7, then 0x10000×0x10000 with MULHU) → start ignored during CALC. Second op accepted in the DONE cycle. Results 0x0000002A then 0x00000001, with done pulses 18 cycles apart.
- rst_n asserted mid-CALC → result, busy and done go to 0 without a clock edge. After release with start=0, the FSM stays in IDLE and no done pulse occurs.
